// File: rtl/fifo_write_scheduler_if.sv
// Write-side bus between four producers, the scheduler and the FIFO write port.
interface fifo_write_scheduler_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_wen;
    logic [DW-1:0]   fifo_wdata;
    logic [1:0]      fifo_wsrc;
    logic [CW-1:0]   credits;
    logic            err;

    modport master (
        output req_valid, req_data, fifo_pop, fifo_full,
        input  req_ready, fifo_wen, fifo_wdata, fifo_wsrc, credits, err
    );

    modport slave (
        input  req_valid, req_data, fifo_pop, fifo_full,
        output req_ready, fifo_wen, fifo_wdata, fifo_wsrc, credits, err
    );
endinterface

// File: rtl/fifo_write_scheduler.sv
// Round-robin, burst-locked, credit-gated scheduler sharing one FIFO write port
// between four producers.
module fifo_write_scheduler #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk_single_domain,
    input  logic                  rst,
    fifo_write_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic            err_q, err_d;
    logic            fifo_wen_q, fifo_wen_d;
    logic [DW-1:0]   fifo_wdata_q, fifo_wdata_d;
    logic [1:0]      fifo_wsrc_q, fifo_wsrc_d;

    logic [3:0]      req_ready;
    logic [2:0]      search;
    logic [1:0]      sel;
    logic            accept;

    // Returns {found, index} of the first valid requester starting at ptr.
    function automatic logic [2:0] first_valid(input logic [3:0] valid, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!res[2] && valid[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_ff @(posedge clk_single_domain) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            credits_q    <= CW'(DEPTH);
            err_q        <= 1'b0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
            fifo_wsrc_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            credits_q    <= credits_d;
            err_q        <= err_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_wsrc_q  <= fifo_wsrc_d;
        end
    end

    // Output decode: ready is the only combinational output.
    always_comb begin
        req_ready = '0;
        search    = first_valid(bus.req_valid, rr_ptr_q);
        sel       = (state_q == LOCKED) ? owner_q : search[1:0];
        if (!rst && credits_q != '0) begin
            if (state_q == LOCKED) req_ready[owner_q] = 1'b1;
            else if (search[2])    req_ready[search[1:0]] = 1'b1;
        end
        accept = |(bus.req_valid & req_ready);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d     = sel;
                    burst_cnt_d = BW'(1);
                    if (MAX_BURST > 1) state_d = LOCKED;
                    else               rr_ptr_d = sel + 2'd1;
                end
            end
            LOCKED: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (burst_cnt_q + BW'(1) == BW'(MAX_BURST)) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_q + 2'd1;
                    end
                end else if (!bus.req_valid[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d    = credits_q;
        err_d        = err_q | (fifo_wen_q & bus.fifo_full);
        fifo_wen_d   = accept;
        fifo_wdata_d = accept ? bus.req_data[int'(sel)*DW +: DW] : '0;
        fifo_wsrc_d  = accept ? sel : fifo_wsrc_q;
        if (accept && !bus.fifo_pop) begin
            credits_d = credits_q - CW'(1);
        end else if (!accept && bus.fifo_pop) begin
            // A pop with every slot already free means the read side miscounted.
            if (credits_q == CW'(DEPTH)) err_d = 1'b1;
            else                         credits_d = credits_q + CW'(1);
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.fifo_wen   = fifo_wen_q;
    assign bus.fifo_wdata = fifo_wdata_q;
    assign bus.fifo_wsrc  = fifo_wsrc_q;
    assign bus.credits    = credits_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Directed and randomized bench for fifo_write_scheduler against a cycle-level
// behavioural model of the arbitration and credit rules.
module tb_fifo_write_scheduler;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_write_scheduler_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    fifo_write_scheduler #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk_single_domain (clk),
        .rst               (rst),
        .bus               (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         m_credits, m_owner, m_ptr, m_count, m_wsrc;
    bit         m_locked, m_err, m_wen, m_init;
    logic [7:0] m_wdata;
    logic [1:0] obs_src[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_ready(input logic [3:0] v);
        if (m_credits == 0) return 4'b0;
        if (m_locked) return 4'b1 << m_owner;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (v[j]) return 4'b1 << j;
        end
        return 4'b0;
    endfunction

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic p,
                        input logic f, input logic r);
        logic [3:0] er;
        int         idx;
        bit         acc;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_pop  = p;
        bus.fifo_full = f;
        rst           = r;
        #1;
        er = r ? 4'b0 : m_ready(v);
        check("req_ready", {28'b0, bus.req_ready}, {28'b0, er});
        if (m_init) begin
            check("fifo_wen", {31'b0, bus.fifo_wen}, {31'b0, m_wen});
            check("fifo_wdata", {24'b0, bus.fifo_wdata}, {24'b0, m_wdata});
            check("credits", {28'b0, bus.credits}, m_credits);
            check("err", {31'b0, bus.err}, {31'b0, m_err});
            if (m_wen) check("fifo_wsrc", {30'b0, bus.fifo_wsrc}, m_wsrc);
        end
        if (bus.fifo_wen === 1'b1) obs_src.push_back(bus.fifo_wsrc);
        if (r) begin
            m_credits = DEPTH; m_owner = 0; m_ptr = 0; m_count = 0; m_wsrc = 0;
            m_locked = 0; m_err = 0; m_wen = 0; m_wdata = '0; m_init = 1;
        end else begin
            acc = (v & er) != 4'b0;
            idx = 0;
            for (int k = 0; k < 4; k++) if (er[k]) idx = k;
            m_err = m_err | (m_wen && f);
            if (acc && !p) m_credits--;
            else if (!acc && p) begin
                if (m_credits == DEPTH) m_err = 1;
                else m_credits++;
            end
            if (!m_locked) begin
                if (acc) begin
                    m_owner = idx; m_count = 1;
                    if (MAXB > 1) m_locked = 1; else m_ptr = (idx + 1) % 4;
                end
            end else if (acc) begin
                m_count++;
                if (m_count == MAXB) begin m_locked = 0; m_ptr = (m_owner + 1) % 4; end
            end else if (!v[m_owner]) begin
                m_locked = 0; m_ptr = (m_owner + 1) % 4;
            end
            m_wen   = acc;
            m_wdata = acc ? d[idx*8 +: 8] : 8'h00;
            if (acc) m_wsrc = idx;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(4'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        obs_src.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_init = 0;
        bus.req_valid = '0; bus.req_data = '0; bus.fifo_pop = 0; bus.fifo_full = 0;

        // Single producer, one full burst.
        do_reset();
        for (int k = 0; k < 4; k++) step(4'b0001, {24'h0, 8'(8'h10 + k)}, 0, 0, 0);
        #1 check("p1_credits", {28'b0, bus.credits}, 4);
        step(4'b1110, 32'hA3A2A1A0, 0, 0, 0);
        step(4'b0000, 32'h0, 0, 0, 0);

        // All producers valid with continuous pops: back-to-back bursts.
        do_reset();
        for (int k = 0; k < 20; k++) step(4'b1111, $urandom, 1, 0, 0);
        #1 check("p2_credits", {28'b0, bus.credits}, 8);
        step(4'b0000, 32'h0, 0, 0, 0);
        check("p2_nwrites", obs_src.size(), 20);
        for (int k = 0; k < 20 && k < obs_src.size(); k++)
            check("p2_src_order", {30'b0, obs_src[k]}, (k / 4) % 4);

        // Credit exhaustion and a single freed slot.
        do_reset();
        for (int k = 0; k < 10; k++) step(4'b0010, $urandom, 0, 0, 0);
        #1 check("p3_credits_zero", {28'b0, bus.credits}, 0);
        check("p3_nwrites", obs_src.size(), 8);
        step(4'b0010, $urandom, 1, 0, 0);
        step(4'b0010, $urandom, 0, 0, 0);
        step(4'b0010, $urandom, 0, 0, 0);
        #1 check("p3_credits_after", {28'b0, bus.credits}, 0);
        check("p3_err", {31'b0, bus.err}, 0);
        check("p3_nwrites_after", obs_src.size(), 9);

        // Owner-initiated release hands over after one bubble.
        do_reset();
        step(4'b1100, $urandom, 0, 0, 0);
        step(4'b1100, $urandom, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(4'b1000, $urandom, 0, 0, 0);
        step(4'b0000, 32'h0, 0, 0, 0);
        check("p4_nwrites", obs_src.size(), 4);
        if (obs_src.size() >= 3) begin
            check("p4_src0", {30'b0, obs_src[0]}, 2);
            check("p4_src2", {30'b0, obs_src[2]}, 3);
        end

        // Accept+pop cancels; pop with all slots free flags an error.
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0001, $urandom, 0, 0, 0);
        step(4'b0001, $urandom, 1, 0, 0);
        #1 check("p5_credits_same", {28'b0, bus.credits}, 5);
        for (int k = 0; k < 3; k++) step(4'b0000, 32'h0, 1, 0, 0);
        step(4'b0000, 32'h0, 1, 0, 0);
        #1 check("p5_err_pop", {31'b0, bus.err}, 1);
        check("p5_credits_full", {28'b0, bus.credits}, 8);
        step(4'b0000, 32'h0, 0, 0, 0);

        // Write landing on a full FIFO flags an error.
        do_reset();
        step(4'b0001, $urandom, 0, 0, 0);
        step(4'b0000, 32'h0, 0, 1, 0);
        #1 check("p5_err_full", {31'b0, bus.err}, 1);
        step(4'b0000, 32'h0, 0, 0, 0);

        // Reset mid-burst.
        do_reset();
        step(4'b0001, $urandom, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(4'b0001, $urandom, 0, 0, 0);
        #1 check("p6_credits_pre", {28'b0, bus.credits}, 3);
        step(4'b0001, $urandom, 0, 0, 1);
        #1 check("p6_wen", {31'b0, bus.fifo_wen}, 0);
        check("p6_credits", {28'b0, bus.credits}, 8);
        check("p6_err", {31'b0, bus.err}, 0);
        step(4'b0100, $urandom, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            logic p;
            p = ($urandom_range(0, 2) == 0) && (m_credits < DEPTH);
            step(4'($urandom), $urandom, p, 0, ($urandom_range(0, 63) == 0));
        end
        step(4'b0000, 32'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_write_scheduler.md
# fifo_write_scheduler

- Shares the single write port of the synchronous 8-entry FIFO between four producers.
- Uses round-robin arbitration with a bounded burst lock.
- Uses credit-based flow control, so no write is ever issued into a full FIFO.
- Sits between the producers and the FIFO's wen/wdata inputs; it replaces the single-source input stage and observes read pops from the read side.

## Interface
Parameters:
- DW, 8, data width per requester.
- DEPTH, 8, FIFO entries; initial and maximum credit count.
- MAX_BURST, 4, maximum consecutive accepts per grant (≥1).

Ports:
- clk_single_domain  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester valid.
- req_data  in  4*DW  requester i data at [i*DW +: DW].
- req_ready  out  4  combinational; one-hot or zero; transfer when valid&ready high at an edge.
- fifo_pop  in  1  one FIFO entry consumed this cycle (ren & ~empty from the read side).
- fifo_full  in  1  FIFO full flag; used only for error checking.
- fifo_wen  out  1  registered write enable to the FIFO.
- fifo_wdata  out  DW  registered write data.
- fifo_wsrc  out  2  registered index of the requester whose data is on fifo_wdata.
- credits  out  4  free FIFO slots as seen by the scheduler (width clog2(DEPTH+1)).
- err  out  1  sticky protocol error.

## Operation
- Credits:
  - Reset to DEPTH.
  - -1 per accept, +1 per fifo_pop.
  - Accept and pop in the same cycle leaves credits unchanged.
  - No accept is possible when credits==0.
  - fifo_pop with credits==DEPTH and no accept: credits unchanged, err set.
- State machine (IDLE, LOCKED); registers: owner[1:0], rr_ptr[1:0], burst_cnt.
- IDLE:
  - If credits>0 and any req_valid is high, grant the first valid requester searching rr_ptr, rr_ptr+1, ... (mod 4).
  - req_ready of that requester is high in the same cycle and the accept happens.
  - owner=idx, burst_cnt=1.
  - Go to LOCKED if MAX_BURST>1, else stay IDLE with rr_ptr=idx+1.
- LOCKED:
  - req_ready[owner] = credits>0; all other ready bits are 0.
  - Accept while req_valid[owner]: burst_cnt+1. On reaching MAX_BURST go to IDLE with rr_ptr=owner+1.
  - req_valid[owner]=0: no transfer this cycle (one bubble); go to IDLE with rr_ptr=owner+1.
  - credits==0 with owner valid: hold LOCKED; burst_cnt unchanged.
- Write issue: every accept registers fifo_wen=1, fifo_wdata=req_data[owner], fifo_wsrc=owner for one cycle. With no accept, fifo_wen=0 and fifo_wdata=0.
- err is set by fifo_wen && fifo_full (overflow reached the FIFO) or by the pop-overflow case above. It is cleared only by rst.

## Timing
- Reset values:
  - fifo_wen=0, fifo_wdata=0, fifo_wsrc=0.
  - credits=DEPTH, err=0.
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - req_ready=0 during rst.
- Latency:
  - Accept at edge N: fifo_wen high N..N+1.
  - The FIFO captures the data at edge N+1.
  - Credits decrement at edge N.
- Throughput: one accept per cycle within a burst; one bubble on an owner-initiated release; no bubble on a MAX_BURST release if another requester is valid (its grant comes in IDLE the next cycle).
- rst mid-burst: the lock is dropped, fifo_wen is deasserted at the reset edge, credits return to DEPTH. The FIFO must be reset in the same cycle.
- fifo_pop is sampled at the same edge as accepts; a freed slot is usable in the cycle after the pop.

## Test plan
- Reset, then req_valid=4'b0001 with data 0x10..0x13 → accepts on 4 consecutive cycles, fifo_wen high 4 cycles, fifo_wsrc=0, credits 8→4, back to IDLE with rr_ptr=1.
- req_valid=4'b1111 held, fifo_pop held high → grants in bursts of 4 in order 0,1,2,3,0; fifo_wsrc sequence 0×4,1×4,2×4,3×4; credits stay 8.
- No pops, req_valid=4'b0010 → exactly 8 accepts, then req_ready=0 and credits=0. A single fifo_pop → one more accept the next cycle, credits back to 0. err stays 0.
- Owner 2 drops valid after 2 accepts while req_valid[3]=1 → one idle cycle, then requester 3 is granted; rr_ptr=3 at the grant.
- Same-cycle accept and fifo_pop with credits=5 → credits stay 5; fifo_pop at credits=8 with no accept → err=1, credits=8.
- rst asserted mid-burst (burst_cnt=2, credits=3) → next cycle fifo_wen=0, credits=8, state IDLE, err=0.
